// File: rtl/hpc_inst_counter_pkg.sv
// Shared core decode constants: RV32 opcodes, instruction classes and counter select encodings.
package hpc_inst_counter_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam int unsigned NumClasses = 7;

  // Enumerator values double as rd_sel codes 0..6 and one-hot bit positions.
  typedef enum logic [2:0] {
    ClsR     = 3'd0,
    ClsI     = 3'd1,
    ClsS     = 3'd2,
    ClsB     = 3'd3,
    ClsU     = 3'd4,
    ClsJ     = 3'd5,
    ClsOther = 3'd6
  } inst_class_e;

  localparam logic [2:0] SelTotal = 3'd7;

  function automatic logic [NumClasses-1:0] class_onehot(input inst_class_e cls);
    return NumClasses'(1) << cls;
  endfunction

endpackage

// File: rtl/hpc_inst_classify.sv
// Combinational opcode decoder producing a one-hot instruction class.
module hpc_inst_classify
  import hpc_inst_counter_pkg::*;
(
  input  logic [6:0]            opcode_i,
  output logic [NumClasses-1:0] class_oh_o
);

  inst_class_e cls;

  always_comb begin
    cls = ClsOther;
    case (opcode_i)
      OpcOp:                                 cls = ClsR;
      OpcLoad, OpcOpImm, OpcJalr, OpcSystem: cls = ClsI;
      OpcStore:                              cls = ClsS;
      OpcBranch:                             cls = ClsB;
      OpcLui, OpcAuipc:                      cls = ClsU;
      OpcJal:                                cls = ClsJ;
      default:                               cls = ClsOther;
    endcase
    class_oh_o = class_onehot(cls);
  end

endmodule

// File: rtl/hpc_inst_counter.sv
// Two-stage saturating per-class instruction counters with a registered read port.
module hpc_inst_counter
  import hpc_inst_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inst_valid_i,
  input  logic [31:0]      inst_i,
  input  logic             flush_i,
  input  logic             clear_i,
  input  logic             freeze_i,
  input  logic             rd_req_i,
  input  logic [2:0]       rd_sel_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [CNT_W-1:0] cnt_r_o,
  output logic [CNT_W-1:0] cnt_i_o,
  output logic [CNT_W-1:0] cnt_s_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] cnt_u_o,
  output logic [CNT_W-1:0] cnt_j_o
);

  localparam int unsigned NumCnt = NumClasses + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NumClasses-1:0] class_oh;
  logic                  cap_valid_q;
  logic [NumClasses-1:0] cap_cls_q;
  logic                  inc_en;
  logic [CNT_W-1:0]      cnt_q [NumCnt];
  logic [CNT_W-1:0]      cnt_d [NumCnt];
  logic                  rd_ack_q;
  logic [CNT_W-1:0]      rd_data_q;
  logic                  unused_inst;

  assign unused_inst = ^inst_i[31:7];

  hpc_inst_classify u_classify (
    .opcode_i   (inst_i[6:0]),
    .class_oh_o (class_oh)
  );

  // Clear also kills the instruction presented alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid_q <= 1'b0;
      cap_cls_q   <= '0;
    end else begin
      cap_valid_q <= inst_valid_i & ~clear_i;
      cap_cls_q   <= class_oh;
    end
  end

  assign inc_en = cap_valid_q & ~flush_i & ~freeze_i;

  always_comb begin
    for (int k = 0; k < NumCnt; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    for (int k = 0; k < NumClasses; k++) begin
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (inc_en && cap_cls_q[k] && (cnt_q[k] != CntMax)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    if (clear_i) begin
      cnt_d[NumClasses] = '0;
    end else if (inc_en && (cnt_q[NumClasses] != CntMax)) begin
      cnt_d[NumClasses] = cnt_q[NumClasses] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumCnt; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumCnt; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Reads sample cnt_q, so a colliding increment or clear is not yet visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= rd_req_i;
      if (rd_req_i) begin
        rd_data_q <= cnt_q[rd_sel_i];
      end
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign cnt_r_o   = cnt_q[ClsR];
  assign cnt_i_o   = cnt_q[ClsI];
  assign cnt_s_o   = cnt_q[ClsS];
  assign cnt_b_o   = cnt_q[ClsB];
  assign cnt_u_o   = cnt_q[ClsU];
  assign cnt_j_o   = cnt_q[ClsJ];

endmodule

// File: tb/tb_hpc_inst_counter.sv
// Directed bench for hpc_inst_counter with a cycle-level reference model and per-cycle compare.
module tb_hpc_inst_counter;

  localparam int unsigned CNT_W = 8;
  localparam longint CntMax = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_valid = 1'b0;
  logic [31:0]      inst = '0;
  logic             flush = 1'b0;
  logic             clear = 1'b0;
  logic             freeze = 1'b0;
  logic             rd_req = 1'b0;
  logic [2:0]       rd_sel = '0;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] cnt_r, cnt_i, cnt_s, cnt_b, cnt_u, cnt_j;

  int n_checks = 0;
  int n_pass = 0;

  // Model: index 0..6 = class counts, 7 = total.
  longint m_cnt [8];
  bit     pend_v = 1'b0;
  int     pend_c = 0;
  bit     m_ack = 1'b0;
  longint m_data = 0;

  hpc_inst_counter #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .inst_valid_i (inst_valid),
    .inst_i       (inst),
    .flush_i      (flush),
    .clear_i      (clear),
    .freeze_i     (freeze),
    .rd_req_i     (rd_req),
    .rd_sel_i     (rd_sel),
    .rd_ack_o     (rd_ack),
    .rd_data_o    (rd_data),
    .cnt_r_o      (cnt_r),
    .cnt_i_o      (cnt_i),
    .cnt_s_o      (cnt_s),
    .cnt_b_o      (cnt_b),
    .cnt_u_o      (cnt_u),
    .cnt_j_o      (cnt_j)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int cls_of(input logic [31:0] w);
    case (w[6:0])
      7'h33:                   return 0;
      7'h03, 7'h13, 7'h67, 7'h73: return 1;
      7'h23:                   return 2;
      7'h63:                   return 3;
      7'h37, 7'h17:            return 4;
      7'h6F:                   return 5;
      default:                 return 6;
    endcase
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    pend_v = 1'b0;
    pend_c = 0;
    m_ack  = 1'b0;
    m_data = 0;
  endtask

  task automatic bump(input int k);
    if (m_cnt[k] < CntMax) m_cnt[k] = m_cnt[k] + 1;
  endtask

  // One clock: the model applies this cycle's inputs at the edge, then inputs may change.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_zero();
    end else begin
      m_ack = rd_req;
      if (rd_req) m_data = m_cnt[rd_sel];
      if (clear) begin
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        pend_v = 1'b0;
      end else begin
        if (pend_v && !flush && !freeze) begin
          bump(pend_c);
          bump(7);
        end
        pend_v = inst_valid;
        pend_c = cls_of(inst);
      end
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    inst_valid = 1'b1;
    inst       = w;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic read_expect(input logic [2:0] sel, input longint exp, input string name);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    chk({name, "_ack"}, rd_ack, 1);
    chk(name, rd_data, exp);
  endtask

  always @(negedge clk) begin
    chk("cnt_r", cnt_r, m_cnt[0]);
    chk("cnt_i", cnt_i, m_cnt[1]);
    chk("cnt_s", cnt_s, m_cnt[2]);
    chk("cnt_b", cnt_b, m_cnt[3]);
    chk("cnt_u", cnt_u, m_cnt[4]);
    chk("cnt_j", cnt_j, m_cnt[5]);
    chk("rd_ack", rd_ack, m_ack);
    chk("rd_data", rd_data, m_data);
  end

  logic [31:0] i_words [4] = '{32'h00002003, 32'h00000013, 32'h00000073, 32'h000000E7};

  initial begin
    model_zero();
    idle(2);
    rst_n = 1'b1;
    chk("rst_cnt_i", cnt_i, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_data", rd_data, 0);

    // Standard program, starting in the first cycle after reset release.
    for (int k = 0; k < 16; k++) issue(i_words[k % 4]);
    for (int k = 0; k < 5; k++) issue(32'h00112023);
    issue(32'h00000463);
    issue(32'h000012B7);
    issue(32'h00000297);
    for (int k = 0; k < 3; k++) issue(32'h0000006F);
    issue(32'h00008067);
    idle(2);
    chk("prog_r", cnt_r, 0);
    chk("prog_i", cnt_i, 32'h11);
    chk("prog_s", cnt_s, 5);
    chk("prog_b", cnt_b, 1);
    chk("prog_u", cnt_u, 2);
    chk("prog_j", cnt_j, 3);
    read_expect(3'd7, 32'h1C, "prog_total");

    // Latency: count visible two cycles after issue, read one cycle after request.
    do_clear();
    issue(32'h00000033);
    chk("lat_early", cnt_r, 0);
    tick();
    chk("lat_r", cnt_r, 1);
    read_expect(3'd0, 1, "lat_rd");

    // Flush cancels only the captured entry; the one presented alongside still counts.
    inst_valid = 1'b1;
    inst = 32'h0000006F;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    inst_valid = 1'b0;
    idle(2);
    chk("flush_j", cnt_j, 1);

    // Freeze over four instructions and their count cycles.
    freeze = 1'b1;
    issue(32'h00000033);
    issue(32'h00000013);
    issue(32'h00000023);
    issue(32'h00000063);
    tick();
    freeze = 1'b0;
    idle(2);
    chk("frz_r", cnt_r, 1);
    chk("frz_i", cnt_i, 0);
    chk("frz_j", cnt_j, 1);

    // Unknown opcode lands in the "other" counter.
    issue(32'h0000000B);
    idle(2);
    read_expect(3'd6, 1, "other");
    read_expect(3'd7, 3, "other_total");

    // Clear colliding with an increment and a total read.
    do_clear();
    for (int k = 0; k < 5; k++) issue(32'h00000013);
    idle(2);
    issue(32'h00000033);
    clear = 1'b1;
    rd_req = 1'b1;
    rd_sel = 3'd7;
    inst_valid = 1'b1;
    inst = 32'h00000013;
    tick();
    clear = 1'b0;
    rd_req = 1'b0;
    inst_valid = 1'b0;
    chk("col_ack", rd_ack, 1);
    chk("col_data", rd_data, 5);
    chk("col_i", cnt_i, 0);
    chk("col_r", cnt_r, 0);
    idle(2);
    chk("col_i_late", cnt_i, 0);

    // Saturation, and total staying pinned while a class counter still moves.
    for (int k = 0; k < 300; k++) issue(32'h00000013);
    idle(2);
    chk("sat_i", cnt_i, 32'hFF);
    read_expect(3'd7, 32'hFF, "sat_total");
    issue(32'h00000063);
    idle(2);
    chk("sat_b", cnt_b, 1);
    read_expect(3'd7, 32'hFF, "sat_total2");

    // Reset mid-stream during a read with an instruction in flight.
    do_clear();
    issue(32'h00000033);
    issue(32'h00000033);
    rd_req = 1'b1;
    rd_sel = 3'd0;
    inst_valid = 1'b1;
    inst = 32'h00000033;
    rst_n = 1'b0;
    model_zero();
    tick();
    rd_req = 1'b0;
    inst_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst_mid_ack", rd_ack, 0);
    chk("rst_mid_r", cnt_r, 0);
    tick();
    chk("rst_mid_ack2", rd_ack, 0);
    issue(32'h00000033);
    issue(32'h00000033);
    idle(2);
    chk("rst_resume_r", cnt_r, 2);
    read_expect(3'd0, 2, "rst_resume_rd");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hpc_inst_counter.md
HPC_INST_COUNTER -- requirements
Module: hpc_inst_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter width in bits (legal 8..32).
REQ-002 SHALL have port clk_i  input  1  core clock; all state on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inst_valid_i  input  1  an issued instruction is presented this cycle.
REQ-005 SHALL have port inst_i  input  32  issued instruction word.
REQ-006 SHALL have port flush_i  input  1  cancels the instruction held in the capture stage.
REQ-007 SHALL have port clear_i  input  1  synchronous clear of all counters.
REQ-008 SHALL have port freeze_i  input  1  while high, no counter increments.
REQ-009 SHALL have port rd_req_i  input  1  counter read request.
REQ-010 SHALL have port rd_sel_i  input  3  counter select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=other, 7=total.
REQ-011 SHALL have port rd_ack_o  output  1  read data valid.
REQ-012 SHALL have port rd_data_o  output  CNT_W  read data.
REQ-013 SHALL have ports cnt_r_o, cnt_i_o, cnt_s_o, cnt_b_o, cnt_u_o, cnt_j_o  output  CNT_W each  live counter values for debug probing.

Function
REQ-014 SHALL classify by inst_i[6:0]:
- 0110011 -> R
- 0000011, 0010011, 1100111 (JALR), 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- any other opcode -> other
REQ-015 SHALL be two-stage:
- Capture stage (cycle N): registers valid plus a one-hot class when inst_valid_i=1.
- Count stage (edge ending cycle N+1): increments the selected counter and total.
- New counts are visible on cnt_*_o from cycle N+2.
REQ-016 SHALL accept one instruction per cycle, back-to-back, with no stall or backpressure.
REQ-017 SHALL drop the capture-stage entry without counting when flush_i=1 in cycle N+1.
REQ-018 SHALL not increment while freeze_i=1 in the count cycle; the entry is discarded, not deferred.
REQ-019 SHALL saturate every counter at 2^CNT_W-1; counters never wrap.
REQ-020 SHALL give clear_i priority over any same-cycle increment: all counters read 0 the next cycle, and the capture stage is invalidated.
REQ-021 SHALL answer a read issued in cycle M with rd_ack_o=1 and rd_data_o in cycle M+1, for exactly one cycle per request; back-to-back requests are allowed.
REQ-022 SHALL return the pre-update value when a read collides with a same-cycle increment or clear.
REQ-023 SHALL hold rd_data_o at its last value and drive rd_ack_o=0 when no read is pending.
REQ-024 SHALL keep total equal to the sum of the seven class counters, except where saturation applies.

Reset
REQ-025 SHALL, while rst_ni=0, immediately force all counters, the capture stage, rd_ack_o and rd_data_o to 0.
REQ-026 SHALL discard any in-flight capture or read when reset is asserted mid-operation; no ack follows release.
REQ-027 SHALL count the first instruction presented in the first cycle after rst_ni rises.

Structure
REQ-028 SHALL take opcode constants, the class enumeration and rd_sel encodings from the shared core package, alongside the existing decode constants.
REQ-029 SHALL use one sub-module, hpc_inst_classify: combinational opcode to one-hot class of width 7.
REQ-030 SHALL be instantiated as u_HPC inside the pipe-control block of the issue stage, fed by issued instructions.

Verification
REQ-031 SHALL cover the standard test program: 17 I, 5 S, 1 B, 2 U, 3 J, 0 R, ending on 0x00008067 -> cnt_r/i/s/b/u/j = 0/0x11/5/1/2/3 and total = 0x1C.
REQ-032 SHALL cover latency: single 0x00000033 at cycle N -> cnt_r_o=1 at N+2; rd_req with sel=0 at N+2 -> rd_ack and data 1 at N+3.
REQ-033 SHALL cover flush and freeze: 0x0000006F at N with flush_i at N+1 -> cnt_j unchanged; freeze_i held over 4 valid instructions -> all counters unchanged.
REQ-034 SHALL cover saturation: CNT_W=8, 300 back-to-back 0x00000013 -> cnt_i=0xFF and total=0xFF.
REQ-035 SHALL cover collisions: clear_i, increment and rd_req (sel=7, total=5) in the same cycle -> read returns 5, all counters 0 next cycle.
REQ-036 SHALL cover reset mid-stream: rst_ni low for 1 cycle during a read -> no ack, all outputs 0, counting resumes correctly afterwards.
